// File: rtl/flag_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : flag_sequencer_pkg
//  Brief    : Shared constants, state/direction encodings and index helpers
//             for the pride-flag sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package flag_sequencer_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int FLAG_IDX_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WIPE = 1'b1
    } seq_state_e;

    typedef enum logic [0:0] {
        DIR_NEXT = 1'b0,
        DIR_PREV = 1'b1
    } seq_dir_e;

    function automatic logic [FLAG_IDX_W-1:0] flag_wrap_inc(
        input logic [FLAG_IDX_W-1:0] idx,
        input int                    num_flags
    );
        return (idx == FLAG_IDX_W'(num_flags - 1)) ? '0 : idx + 1'b1;
    endfunction

    function automatic logic [FLAG_IDX_W-1:0] flag_wrap_dec(
        input logic [FLAG_IDX_W-1:0] idx,
        input int                    num_flags
    );
        return (idx == '0) ? FLAG_IDX_W'(num_flags - 1) : idx - 1'b1;
    endfunction

    function automatic logic [FLAG_IDX_W-1:0] flag_step(
        input logic [FLAG_IDX_W-1:0] idx,
        input seq_dir_e              dir,
        input int                    num_flags
    );
        return (dir == DIR_NEXT) ? flag_wrap_inc(idx, num_flags)
                                 : flag_wrap_dec(idx, num_flags);
    endfunction

endpackage
`default_nettype wire

// File: rtl/flag_seq_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : flag_seq_debounce
//  Brief    : Frame-sampled button debouncer; emits a one-cycle pulse on the
//             frame_start where the debounced level rises.
//  Revision : 1.0  initial release
// ============================================================================
module flag_seq_debounce
    import flag_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_frame_start,
    input  logic i_btn_raw,
    output logic o_rise
);

    localparam int                 c_cnt_w    = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_FRAMES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_differs;
    logic               w_settle;

    // r_cnt counts prior consecutive samples that disagree with r_level
    assign w_differs = r_sync2 ^ r_level;
    assign w_settle  = i_frame_start && w_differs && (r_cnt == c_cnt_last);
    assign o_rise    = w_settle && r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
            if (i_frame_start) begin
                if (!w_differs) begin
                    r_cnt <= '0;
                end else if (w_settle) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/flag_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : flag_sequencer
//  Brief    : Selects the displayed pride flag and wipes between flags one
//             step per frame. Optional WIPE_DITHER_EN adds a checkerboard edge.
//  Revision : 1.0  initial release
// ============================================================================
module flag_sequencer
    import flag_sequencer_pkg::*;
#(
    parameter int NUM_FLAGS       = 16,
    parameter int HOLD_FRAMES     = 256,
    parameter int WIPE_STEP       = 16,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic [9:0]            pix_x,
    input  logic [9:0]            pix_y,
    input  logic                  btn_next,
    input  logic                  btn_prev,
    input  logic                  auto_en,
    output logic [FLAG_IDX_W-1:0] flag_cur,
    output logic [FLAG_IDX_W-1:0] flag_nxt,
    output logic                  show_nxt,
    output logic                  busy
);

    localparam int                  c_hold_w    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_FRAMES - 1);
    localparam logic [10:0]         c_step      = 11'(WIPE_STEP);
    localparam logic [10:0]         c_h_active  = 11'(H_ACTIVE);

    seq_state_e            r_state,    w_state_nxt;
    logic [FLAG_IDX_W-1:0] r_flag_cur, w_flag_cur_nxt;
    logic [FLAG_IDX_W-1:0] r_flag_nxt, w_flag_nxt_nxt;
    logic [9:0]            r_wipe_pos, w_wipe_pos_nxt;
    logic [c_hold_w-1:0]   r_hold_cnt, w_hold_cnt_nxt;
    logic                  r_pending,  w_pending_nxt;
    seq_dir_e              r_pend_dir, w_pend_dir_nxt;

    logic                  w_req_next;
    logic                  w_req_prev;
    logic                  w_req_man;
    seq_dir_e              w_req_dir;
    logic [10:0]           w_wipe_sum;
    logic                  w_start;
    seq_dir_e              w_start_dir;
    logic [FLAG_IDX_W-1:0] w_start_base;

    flag_seq_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb_next (
        .clk           (clk),
        .reset         (reset),
        .i_frame_start (frame_start),
        .i_btn_raw     (btn_next),
        .o_rise        (w_req_next)
    );

    flag_seq_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb_prev (
        .clk           (clk),
        .reset         (reset),
        .i_frame_start (frame_start),
        .i_btn_raw     (btn_prev),
        .o_rise        (w_req_prev)
    );

    assign w_req_man  = w_req_next || w_req_prev;
    assign w_req_dir  = w_req_next ? DIR_NEXT : DIR_PREV;
    assign w_wipe_sum = {1'b0, r_wipe_pos} + c_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_flag_cur <= '0;
            r_flag_nxt <= '0;
            r_wipe_pos <= '0;
            r_hold_cnt <= '0;
            r_pending  <= 1'b0;
            r_pend_dir <= DIR_NEXT;
        end else begin
            r_state    <= w_state_nxt;
            r_flag_cur <= w_flag_cur_nxt;
            r_flag_nxt <= w_flag_nxt_nxt;
            r_wipe_pos <= w_wipe_pos_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_pending  <= w_pending_nxt;
            r_pend_dir <= w_pend_dir_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_flag_cur_nxt = r_flag_cur;
        w_flag_nxt_nxt = r_flag_nxt;
        w_wipe_pos_nxt = r_wipe_pos;
        w_hold_cnt_nxt = r_hold_cnt;
        w_pending_nxt  = r_pending;
        w_pend_dir_nxt = r_pend_dir;
        w_start        = 1'b0;
        w_start_dir    = DIR_NEXT;
        w_start_base   = r_flag_cur;

        if (frame_start) begin
            case (r_state)
                ST_IDLE: begin
                    // A fresh button press overrides any queued request
                    if (w_req_man) begin
                        w_start       = 1'b1;
                        w_start_dir   = w_req_dir;
                        w_start_base  = r_flag_cur;
                        w_pending_nxt = 1'b0;
                    end else if (r_pending) begin
                        w_start       = 1'b1;
                        w_start_dir   = r_pend_dir;
                        w_start_base  = r_flag_nxt;
                        w_pending_nxt = 1'b0;
                    end else if (auto_en) begin
                        if (r_hold_cnt == c_hold_last) begin
                            w_start      = 1'b1;
                            w_start_dir  = DIR_NEXT;
                            w_start_base = r_flag_cur;
                        end else begin
                            w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                        end
                    end else begin
                        w_hold_cnt_nxt = '0;
                    end
                end
                ST_WIPE: begin
                    if (w_req_man) begin
                        w_pending_nxt  = 1'b1;
                        w_pend_dir_nxt = w_req_dir;
                    end
                    if (w_wipe_sum >= c_h_active) begin
                        w_flag_cur_nxt = r_flag_nxt;
                        w_wipe_pos_nxt = '0;
                        w_state_nxt    = ST_IDLE;
                    end else begin
                        w_wipe_pos_nxt = w_wipe_sum[9:0];
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        if (w_start) begin
            w_flag_nxt_nxt = flag_step(w_start_base, w_start_dir, NUM_FLAGS);
            w_hold_cnt_nxt = '0;
            w_wipe_pos_nxt = '0;
            w_state_nxt    = ST_WIPE;
        end
    end

    logic w_in_wipe;
    logic w_hard;
    logic w_dither;
    logic w_unused_pix_y;

    assign w_in_wipe = (r_state == ST_WIPE);
    assign w_hard    = (pix_x < r_wipe_pos);

`ifdef WIPE_DITHER_EN
    logic [10:0] w_edge_end;
    assign w_edge_end     = {1'b0, r_wipe_pos} + 11'd8;
    assign w_dither       = !w_hard && ({1'b0, pix_x} < w_edge_end) && (pix_x[0] ^ pix_y[0]);
    assign w_unused_pix_y = ^pix_y[9:1];
`else
    assign w_dither       = 1'b0;
    assign w_unused_pix_y = ^pix_y;
`endif

    assign show_nxt = w_in_wipe && (w_hard || w_dither);
    assign busy     = w_in_wipe;
    assign flag_cur = r_flag_cur;
    assign flag_nxt = r_flag_nxt;

endmodule
`default_nettype wire

// File: tb/tb_flag_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flag_sequencer
//  Brief    : Directed self-checking bench for flag_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_flag_sequencer;

    logic       clk         = 1'b0;
    logic       reset       = 1'b1;
    logic       frame_start = 1'b0;
    logic [9:0] pix_x       = '0;
    logic [9:0] pix_y       = '0;
    logic       btn_next    = 1'b0;
    logic       btn_prev    = 1'b0;
    logic       auto_en     = 1'b0;
    logic [3:0] flag_cur;
    logic [3:0] flag_nxt;
    logic       show_nxt;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    flag_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .btn_next    (btn_next),
        .btn_prev    (btn_prev),
        .auto_en     (auto_en),
        .flag_cur    (flag_cur),
        .flag_nxt    (flag_nxt),
        .show_nxt    (show_nxt),
        .busy        (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each frame: a few idle cycles, then one frame_start pulse
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (3) tick();
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            tick();
        end
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    task automatic probe(input string tag, input int x, input logic exp);
        pix_x = 10'(x);
        #1;
        check(tag, show_nxt, exp);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        check("rst_cur",  flag_cur, 0);
        check("rst_nxt",  flag_nxt, 0);
        check("rst_busy", busy,     0);
        check("rst_show", show_nxt, 0);
        reset = 1'b0;

        // Held next button: request lands on the 4th sampled frame
        btn_next = 1'b1;
        frames(3);
        check("deb3_busy", busy, 0);
        frames(1);
        check("deb4_nxt",  flag_nxt, 1);
        check("deb4_busy", busy,     1);
        check("deb4_cur",  flag_cur, 0);
        probe("wipe0_x0", 0, 1'b0);
        frames(1);
        btn_next = 1'b0;
        probe("wipe16_x15", 15, 1'b1);
        probe("wipe16_x16", 16, 1'b0);
        frames(38);
        check("wipe624_busy", busy, 1);
        probe("wipe624_x623", 623, 1'b1);
        probe("wipe624_x624", 624, 1'b0);
        frames(1);
        check("done1_cur",  flag_cur, 1);
        check("done1_nxt",  flag_nxt, 1);
        check("done1_busy", busy,     0);
        probe("done1_show", 0, 1'b0);

        // Prev from flag 0 wraps to the last flag
        pulse_reset();
        btn_prev = 1'b1;
        frames(4);
        check("prev_wrap_nxt",  flag_nxt, 15);
        check("prev_wrap_busy", busy,     1);
        btn_prev = 1'b0;
        frames(20);
        probe("mid_x319", 319, 1'b1);
        probe("mid_x320", 320, 1'b0);
        frames(20);
        check("prev_done_cur",  flag_cur, 15);
        check("prev_done_busy", busy,     0);
        btn_next = 1'b1;
        frames(4);
        check("next_wrap_nxt", flag_nxt, 0);
        btn_next = 1'b0;
        frames(40);
        check("next_wrap_cur", flag_cur, 0);

        // Three-frame glitch never qualifies
        btn_next = 1'b1;
        frames(3);
        btn_next = 1'b0;
        frames(5);
        check("glitch_busy", busy,     0);
        check("glitch_nxt",  flag_nxt, 0);
        check("glitch_cur",  flag_cur, 0);

        // Auto-advance cadence
        pulse_reset();
        auto_en = 1'b1;
        frames(255);
        check("auto255_busy", busy, 0);
        frames(1);
        check("auto256_busy", busy,     1);
        check("auto256_nxt",  flag_nxt, 1);
        frames(40);
        check("auto1_cur",  flag_cur, 1);
        check("auto1_busy", busy,     0);
        frames(255);
        check("auto2_wait_busy", busy, 0);
        frames(1);
        check("auto2_busy", busy,     1);
        check("auto2_nxt",  flag_nxt, 2);
        auto_en = 1'b0;
        frames(40);
        check("auto2_cur", flag_cur, 2);

        // Reach flag 3, then queue next-then-prev during the 3->4 wipe
        btn_next = 1'b1;
        frames(4);
        btn_next = 1'b0;
        frames(40);
        check("to3_cur", flag_cur, 3);
        btn_next = 1'b1;
        frames(4);
        check("w34_nxt",  flag_nxt, 4);
        check("w34_busy", busy,     1);
        btn_next = 1'b0;
        frames(4);
        btn_next = 1'b1;
        frames(4);
        btn_next = 1'b0;
        btn_prev = 1'b1;
        frames(4);
        btn_prev = 1'b0;
        check("pend_keep_nxt", flag_nxt, 4);
        frames(28);
        check("w34_done_cur",  flag_cur, 4);
        check("w34_done_busy", busy,     0);
        frames(1);
        check("pend_start_busy", busy,     1);
        check("pend_start_nxt",  flag_nxt, 3);
        frames(40);
        check("pend_done_cur", flag_cur, 3);

        // Reset in the middle of a wipe with a queued request
        btn_next = 1'b1;
        frames(4);
        btn_next = 1'b0;
        frames(4);
        btn_next = 1'b1;
        frames(4);
        btn_next = 1'b0;
        frames(2);
        probe("w160_x159", 159, 1'b1);
        probe("w160_x160", 160, 1'b0);
        pix_x = 10'd100;
        reset = 1'b1;
        tick();
        check("mrst_cur",  flag_cur, 0);
        check("mrst_nxt",  flag_nxt, 0);
        check("mrst_busy", busy,     0);
        check("mrst_show", show_nxt, 0);
        reset = 1'b0;
        frames(5);
        check("mrst_nopend_busy", busy,     0);
        check("mrst_nopend_cur",  flag_cur, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
